regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the register file between NUM_REQ requesters
//  (e.g. ALU writeback, load unit, mult/div unit, debug port).
//  Round-robin arbitration with a req/ack handshake; drives registered enable/addr/data to the regfile.
//  Sits between the writeback sources and the register file; one write per cycle maximum.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   5   register address width
//  DATA_W   32  register data width
// PORTS
//  clk        in   1                 rising-edge clock; the single clock of the block
//  reset      in   1                 asynchronous, active-high reset
//  stall      in   1                 1 = issue no grant this cycle
//  req        in   NUM_REQ           per-requester write request, held until acked
//  req_addr   in   NUM_REQ*ADDR_W    requester i address at bits [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W    requester i data at bits [i*DATA_W +: DATA_W]
//  ack        out  NUM_REQ           one-hot, 1-cycle pulse: request i has been accepted
//  wr_enable  out  1                 register-file write enable
//  wr_addr    out  ADDR_W            register-file write address
//  wr_data    out  DATA_W            register-file write data
//  ptr        out  clog2(NUM_REQ)    current highest-priority requester (debug/visibility)
// BEHAVIOUR
//  - Reset (async): ack=0, wr_enable=0, wr_addr=0, wr_data=0, ptr=0. Applies mid-transaction;
//    a write registered on the cycle reset asserts is discarded. Requesters re-present requests after reset.
//  - Eligible set each cycle: req & ~ack. The requester acked this cycle cannot win this cycle,
//    so it may drop or replace req/addr/data in response to ack without a double write.
//  - Winner: first eligible index scanning ptr, ptr+1, ..., wrapping NUM_REQ-1 -> 0.
//  - At rising edge, with a winner and stall=0: ack <= onehot(winner); wr_addr/wr_data <= winner's
//    addr/data; wr_enable <= (winner addr != 0); ptr <= (winner+1) mod NUM_REQ.
//  - Writes to address 0 are acked (consumed) but never enabled; $0 stays zero.
//  - No winner, or stall=1: ack <= 0, wr_enable <= 0, ptr unchanged; wr_addr/wr_data hold their values.
//  - Latency: req sampled at edge t -> ack/wr_* valid during cycle t..t+1 -> regfile writes at edge t+1.
//  - Throughput: one write per cycle across requesters; any single requester at most every 2nd cycle.
//  - Fairness: a continuously requesting requester is granted within NUM_REQ grants.
//  - ack and wr_enable are never high for a requester whose req was low at the sampling edge.
//  - Dropping req before ack withdraws the request (legal); changing addr/data while req is high
//    and unacked is allowed; the values sampled at the granting edge are the ones written.
// STRUCTURE
//  - Shared package regfile_pkg: ADDR_W, DATA_W, ZERO_REG (=0), NUM_WB_SRC; requester index constants.
//  - Sub-module rr_pick (combinational): inputs eligible[NUM_REQ], ptr; outputs found, winner index.
//  - Top level: rr_pick, operand mux, output/ptr registers with async reset.
// TESTING
//  - Reset: hold reset 2 cycles with req=4'b1111 -> ack=0, wr_enable=0, ptr=0 throughout;
//    reset pulsed mid-burst -> outputs clear immediately (async).
//  - Single requester: req[1]=1, addr=7, data=10 -> next cycle ack=4'b0010, wr_enable=1, wr_addr=7,
//    wr_data=10, ptr=2; regfile q of r7 reads 10 after the following edge.
//  - Contention: req=4'b1111 held, each requester re-requesting immediately after its ack ->
//    grant order 0,1,2,3,0,...; a write every cycle; no requester acked in two consecutive cycles.
//  - Zero register: req[2]=1, addr=0, data=88 -> ack=4'b0100, wr_enable=0; r0 still reads 0.
//  - Stall: req[3]=1 with stall=1 for 3 cycles -> no ack, ptr unchanged; stall drops -> ack[3] next cycle.
//  - Back-to-back/hold: requester 0 keeps req high after ack with data 88 then 89 -> two separate
//    writes with at least one idle-for-it cycle between; wr_data shows 88 then 89, never 88 twice.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write path.
// Requester index map for the writeback sources.
package regfile_pkg;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int ZERO_REG   = 0;
    localparam int NUM_WB_SRC = 4;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;
    localparam int REQ_DEBUG  = 3;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'(REQ_ALU),
        SRC_LOAD   = 2'(REQ_LOAD),
        SRC_MULDIV = 2'(REQ_MULDIV),
        SRC_DEBUG  = 2'(REQ_DEBUG)
    } wb_src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle and register-file write port of the arbiter.
// master = writeback sources, slave = arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = regfile_pkg::NUM_WB_SRC,
    parameter int AW      = regfile_pkg::ADDR_W,
    parameter int DW      = regfile_pkg::DATA_W
);
    localparam int PW = $clog2(NUM_REQ);

    logic                  stall;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  wr_enable;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic [PW-1:0]         ptr;

    modport master (
        output stall, req, req_addr, req_data,
        input  ack, wr_enable, wr_addr, wr_data, ptr
    );

    modport slave (
        input  stall, req, req_addr, req_data,
        output ack, wr_enable, wr_addr, wr_data, ptr
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index
// starting at ptr and wrapping around.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = regfile_pkg::NUM_WB_SRC,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      ptr,
    output logic               found,
    output logic [PW-1:0]      winner
);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port
// among NUM_REQ writeback sources; registered ack and write outputs.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = regfile_pkg::NUM_WB_SRC,
    parameter int AW      = regfile_pkg::ADDR_W,
    parameter int DW      = regfile_pkg::DATA_W
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] ack_q;
    logic               wr_enable_q;
    logic [AW-1:0]      wr_addr_q;
    logic [DW-1:0]      wr_data_q;
    logic [PW-1:0]      ptr_q;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [PW-1:0]      winner;
    logic [AW-1:0]      addr_sel;
    logic [DW-1:0]      data_sel;
    logic [PW-1:0]      ptr_next;

    // A requester being acked this cycle may still show req; skip it.
    assign eligible = bus.req & ~ack_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (found),
        .winner   (winner)
    );

    assign addr_sel = bus.req_addr[int'(winner)*AW +: AW];
    assign data_sel = bus.req_data[int'(winner)*DW +: DW];
    assign ptr_next = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q       <= '0;
            wr_enable_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ptr_q       <= '0;
        end else if (found && !bus.stall) begin
            ack_q       <= NUM_REQ'(1) << winner;
            wr_addr_q   <= addr_sel;
            wr_data_q   <= data_sel;
            wr_enable_q <= (addr_sel != AW'(ZERO_REG));
            ptr_q       <= ptr_next;
        end else begin
            ack_q       <= '0;
            wr_enable_q <= 1'b0;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.wr_enable = wr_enable_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small
// behavioural register file on the write port.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [31:0] rf [32];

    regfile_write_arbiter_if #(.NUM_REQ(4), .AW(5), .DW(32)) bus ();

    regfile_write_arbiter #(.NUM_REQ(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_enable) rf[bus.wr_addr] <= bus.wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a,
                           input logic [31:0] d);
        bus.req[i]             = 1'b1;
        bus.req_addr[i*5 +: 5]  = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*5 +: 5] = 5'(i + 1);
            bus.req_data[i*32 +: 32] = 32'(i + 1);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (bus.ack !== 4'b0000 || bus.wr_enable !== 1'b0
                || bus.ptr !== 2'd0) begin
                n_err++;
                $display("FAIL reset_hold: ack=%b we=%b ptr=%0d want 0/0/0",
                         bus.ack, bus.wr_enable, bus.ptr);
            end
        end
        bus.req = 4'b0000;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_wr: addr=%0d data=%0d want 0/0",
                     bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_single();
        set_req(1, 5'd7, 32'd10);
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0010 || bus.wr_enable !== 1'b1) begin
            n_err++;
            $display("FAIL single_ack: ack=%b we=%b want 0010/1",
                     bus.ack, bus.wr_enable);
        end
        n_cmp++;
        if (bus.wr_addr !== 5'd7 || bus.wr_data !== 32'd10
            || bus.ptr !== 2'd2) begin
            n_err++;
            $display("FAIL single_wr: addr=%0d data=%0d ptr=%0d want 7/10/2",
                     bus.wr_addr, bus.wr_data, bus.ptr);
        end
        bus.req = 4'b0000;
        tick();
        n_cmp++;
        if (rf[7] !== 32'd10 || bus.ack !== 4'b0000) begin
            n_err++;
            $display("FAIL single_rf: r7=%0d ack=%b want 10/0000",
                     rf[7], bus.ack);
        end
    endtask

    task automatic test_contention();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 5'(8 + i), 32'(100 + i));
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus.ack !== (4'b0001 << (k % 4)) || bus.wr_enable !== 1'b1
                || bus.wr_addr !== 5'(8 + k % 4)
                || bus.wr_data !== 32'(100 + k % 4)) begin
                n_err++;
                $display("FAIL contend_%0d: ack=%b we=%b addr=%0d data=%0d want %b/1/%0d/%0d",
                         k, bus.ack, bus.wr_enable, bus.wr_addr, bus.wr_data,
                         4'b0001 << (k % 4), 8 + k % 4, 100 + k % 4);
            end
        end
        n_cmp++;
        if (rf[10] !== 32'd102) begin
            n_err++;
            $display("FAIL contend_rf: r10=%0d want 102", rf[10]);
        end
        // Asynchronous reset in the middle of the burst.
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.ack !== 4'b0000 || bus.wr_enable !== 1'b0
            || bus.ptr !== 2'd0) begin
            n_err++;
            $display("FAIL midreset: ack=%b we=%b ptr=%0d want 0/0/0",
                     bus.ack, bus.wr_enable, bus.ptr);
        end
        bus.req = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        set_req(2, 5'd0, 32'd88);
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0100 || bus.wr_enable !== 1'b0
            || bus.ptr !== 2'd3) begin
            n_err++;
            $display("FAIL zero_ack: ack=%b we=%b ptr=%0d want 0100/0/3",
                     bus.ack, bus.wr_enable, bus.ptr);
        end
        bus.req = 4'b0000;
        tick();
        n_cmp++;
        if (rf[0] !== 32'd0) begin
            n_err++;
            $display("FAIL zero_rf: r0=%0d want 0", rf[0]);
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        set_req(3, 5'd9, 32'd55);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bus.ack !== 4'b0000 || bus.wr_enable !== 1'b0
                || bus.ptr !== 2'd3) begin
                n_err++;
                $display("FAIL stall_%0d: ack=%b we=%b ptr=%0d want 0/0/3",
                         c, bus.ack, bus.wr_enable, bus.ptr);
            end
        end
        bus.stall = 1'b0;
        tick();
        n_cmp++;
        if (bus.ack !== 4'b1000 || bus.wr_addr !== 5'd9
            || bus.ptr !== 2'd0) begin
            n_err++;
            $display("FAIL stall_release: ack=%b addr=%0d ptr=%0d want 1000/9/0",
                     bus.ack, bus.wr_addr, bus.ptr);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        set_req(0, 5'd5, 32'd88);
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0001 || bus.wr_enable !== 1'b1
            || bus.wr_data !== 32'd88) begin
            n_err++;
            $display("FAIL b2b_first: ack=%b we=%b data=%0d want 0001/1/88",
                     bus.ack, bus.wr_enable, bus.wr_data);
        end
        bus.req_data[31:0] = 32'd89;
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0000 || bus.wr_enable !== 1'b0
            || bus.wr_data !== 32'd88) begin
            n_err++;
            $display("FAIL b2b_gap: ack=%b we=%b data=%0d want 0000/0/88",
                     bus.ack, bus.wr_enable, bus.wr_data);
        end
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0001 || bus.wr_enable !== 1'b1
            || bus.wr_data !== 32'd89) begin
            n_err++;
            $display("FAIL b2b_second: ack=%b we=%b data=%0d want 0001/1/89",
                     bus.ack, bus.wr_enable, bus.wr_data);
        end
        bus.req = 4'b0000;
        tick();
        n_cmp++;
        if (rf[5] !== 32'd89 || bus.ack !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_rf: r5=%0d ack=%b want 89/0000",
                     rf[5], bus.ack);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero();
        test_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
